bk_add_sequencer: RTL
=====================

# bk_add_sequencer

Multi-cycle wide-operand add/subtract controller built around the team's 16-bit Brent-Kung adder. It accepts W-bit operands over a valid/ready request channel and feeds them to one external N-bit adder instance one slice per cycle, LSB slice first, chaining the carry between slices. It then returns the W-bit result, carry-out and signed overflow on a valid/ready response channel. It sits between the issuing logic and the shared adder datapath, and owns all adder input ports.

## Interface
- N, 16: adder slice width; must equal the attached adder's width.
- W, 64: operand width; must be a multiple of N; K = W/N slices (4 by default).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_sub  in  1  1 = A − B, 0 = A + B.
- req_cin  in  1  carry-in for add; ignored when req_sub=1.
- rsp_valid  out  1  result present; high only in DONE.
- rsp_ready  in  1  consumer accepts the result.
- rsp_sum  out  W  result.
- rsp_cout  out  1  carry out of bit W-1 (for sub: 1 = no borrow).
- rsp_ovf  out  1  two's-complement signed overflow.
- add_a  out  N  adder operand A slice.
- add_b  out  N  adder operand B slice, already inverted for sub.
- add_cin  out  1  adder carry-in.
- add_sum  in  N+1  adder result {carry, sum}; combinational from add_a/add_b/add_cin.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid=1, the controller latches:
  - a_reg = req_a;
  - b_reg = req_sub ? ~req_b : req_b;
  - carry = req_sub ? 1 : req_cin;
  - idx = 0.
  
  It then goes to RUN.
- RUN: each cycle it drives add_a = a_reg[idx*N +: N], add_b = b_reg[idx*N +: N] and add_cin = carry. At the edge it writes add_sum[N-1:0] into sum_reg[idx*N +: N], sets carry = add_sum[N] and increments idx. After idx = K-1 is written, it goes to DONE.
- DONE: rsp_valid=1. rsp_sum = sum_reg, rsp_cout = carry and rsp_ovf are held stable until rsp_ready=1, then it returns to IDLE.
- Overflow: rsp_ovf = (a_reg[W-1] == b_reg[W-1]) && (sum_reg[W-1] != a_reg[W-1]), using the effective (inverted for sub) B.
- Outside RUN, add_a, add_b and add_cin are driven to 0.
- Requests arriving while not in IDLE are not accepted. req_valid may stay high; it is accepted on the first IDLE cycle.
- rsp_valid never drops without rsp_ready.
- Reset mid-operation: all state clears immediately and the in-flight transaction is discarded. No response is produced for it.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, add_a=0, add_b=0, add_cin=0, idx=0.
- Request accepted at edge E0. RUN occupies cycles E0+1 … E0+K. rsp_valid rises after edge E0+K (K=4: rsp_valid high in the 5th cycle after acceptance).
- A response accepted at edge Er puts the controller in IDLE (req_ready=1) in the cycle after Er.
- Minimum initiation interval is K+2 cycles (K+2 = 6 by default).
- Only one adder evaluation per cycle. The adder is combinational with no pipeline stage; its result is captured in the same cycle it is driven.

## Test plan
- Add with carry ripple: A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> rsp_sum=0x0000_0000_0001_0000, cout=0, ovf=0. Adder trace must be add_a=0xFFFF/0x0000/0x0000/0x0000 with add_cin=0/1/0/0. rsp_valid must be high exactly 5 cycles after acceptance.
- Full wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> rsp_sum=0, cout=1, ovf=0. Separately, A=0x7FFF_FFFF_FFFF_FFFF, B=0, cin=1 -> rsp_sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Subtract:
  - A=5, B=7, sub=1 -> rsp_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
  - A=0x8000_0000_0000_0000, B=1, sub=1 -> rsp_sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
  - req_cin toggled during sub has no effect.
- Back-pressure: hold rsp_ready=0 for 3 cycles in DONE with a second request pending on req_valid. rsp_* must stay stable and req_ready must stay 0. After the rsp_ready handshake, the second request is accepted in the next cycle and its result is correct.
- Reset mid-operation: assert rst_n=0 during RUN slice idx=2. All outputs must take their reset values without waiting for a clock edge. After release, req_ready=1 and no rsp_valid appears until a new request completes.
- Back-to-back random: 1000 random add/sub requests with random req_valid/rsp_ready gaps. Each result must match a W-bit reference model (sum, cout, ovf), and no response may be lost or duplicated.

Source files
------------

// File: rtl/bk_add_sequencer_if.sv
// Request/response channels of the wide add/subtract sequencer.
// The issuing logic holds the master side; the sequencer holds the slave side.
interface bk_add_sequencer_if #(
  parameter int W = 64
);
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_sub;
  logic         req_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/bk_add_sequencer.sv
// Wide add/subtract controller: streams W-bit operands through one external
// N-bit adder, LSB slice first, chaining the carry between slices.
module bk_add_sequencer #(
  parameter int N = 16,
  parameter int W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  bk_add_sequencer_if.slave   bus,
  output logic [N-1:0]        add_a,
  output logic [N-1:0]        add_b,
  output logic                add_cin,
  input  logic [N:0]          add_sum
);

  localparam int K     = W / N;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [K-1:0][N-1:0]   a_reg;
  logic [K-1:0][N-1:0]   b_reg;
  logic [K-1:0][N-1:0]   sum_reg;
  logic                  carry;
  logic [IDX_W-1:0]      idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and a latch can never be inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.req_valid)   state_next = RUN;
      RUN:     if (idx == LAST_IDX) state_next = DONE;
      DONE:    if (bus.rsp_ready)   state_next = IDLE;
      default:                      state_next = IDLE;
    endcase
  end

  // NOTE: the operand and result registers are reset too, because the
  // response outputs expose them directly and must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_reg <= bus.req_a;
            // Subtraction is A + ~B + 1: invert B here and force the carry-in.
            b_reg <= bus.req_sub ? ~bus.req_b : bus.req_b;
            carry <= bus.req_sub | bus.req_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= add_sum[N-1:0];
          carry        <= add_sum[N];
          idx          <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // The adder is idle-quiet: its inputs are zero whenever no slice is in flight.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[idx];
      add_b   = b_reg[idx];
      add_cin = carry;
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_sum   = sum_reg;
  assign bus.rsp_cout  = carry;
  assign bus.rsp_ovf   = (a_reg[K-1][N-1] == b_reg[K-1][N-1]) &&
                         (sum_reg[K-1][N-1] != a_reg[K-1][N-1]);

endmodule
